// File: rtl/vend_machine_param.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : vend_machine_param                                             |
// | Purpose  : Single-item vending controller. Coins add credit, reaching     |
// |            PRICE releases the item, overpayment is returned one 50-unit   |
// |            change pulse per cycle. The REFUND path for cancel exists only |
// |            when the macro VEND_CANCEL_EN is defined.                      |
// | Ports    : clk          - rising-edge clock                               |
// |            reset_n      - asynchronous active-low reset                   |
// |            coin_valid   - coin offered this cycle                         |
// |            coin_val     - coin value (50-unit steps)                      |
// |            cancel       - refund request (VEND_CANCEL_EN builds only)     |
// |            dispense_ack - mechanism has taken the item                    |
// |            coin_ready   - machine accepting coins (decoded from state)    |
// |            coin_reject  - one-cycle pulse, offered coin returned          |
// |            dispense     - item release request, held until ack           |
// |            change       - one-cycle pulse per change/refund unit          |
// |            credit       - held credit, registered                         |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module vend_machine_param #(
   parameter int CREDIT_W   = 8,
   parameter int PRICE      = 3,
   parameter int MAX_CREDIT = 15
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                coin_valid,
   input  logic [CREDIT_W-1:0] coin_val,
   input  logic                cancel,
   input  logic                dispense_ack,
   output logic                coin_ready,
   output logic                coin_reject,
   output logic                dispense,
   output logic                change,
   output logic [CREDIT_W-1:0] credit
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_VEND    = 3'd2,
      ST_CHANGE  = 3'd3,
      ST_REFUND  = 3'd4
   } state_t;

   localparam logic [CREDIT_W-1:0] c_price = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] c_one   = CREDIT_W'(1);
   localparam logic [CREDIT_W:0]   c_max   = (CREDIT_W+1)'(MAX_CREDIT);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                dispense_q, dispense_d;
   logic                change_q, change_d;
   logic                coin_reject_q, coin_reject_d;

   // One extra bit so an over-limit sum can never wrap back under MAX_CREDIT.
   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_ok;

`ifdef VEND_CANCEL_EN
   // A cancel arriving with a coin is remembered and acted on one cycle later.
   logic                cancel_pend_q, cancel_pend_d;
   logic                w_cancel_req;
   assign w_cancel_req = cancel | cancel_pend_q;
`else
   logic                w_unused_cancel;
   assign w_unused_cancel = cancel;
`endif

   assign coin_ready  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
   assign coin_reject = coin_reject_q;
   assign dispense    = dispense_q;
   assign change      = change_q;
   assign credit      = credit_q;

   assign w_sum     = {1'b0, credit_q} + {1'b0, coin_val};
   assign w_coin_ok = coin_valid && coin_ready && (coin_val != '0) && (w_sum <= c_max);

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      dispense_d    = dispense_q;
      change_d      = 1'b0;
      coin_reject_d = coin_valid && !w_coin_ok;
`ifdef VEND_CANCEL_EN
      cancel_pend_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_coin_ok) begin
               credit_d = w_sum[CREDIT_W-1:0];
               state_d  = ST_COLLECT;
`ifdef VEND_CANCEL_EN
               cancel_pend_d = cancel;
`endif
            end
         end
         ST_COLLECT: begin
            if (credit_q >= c_price) begin
               // Vend has priority; a legal coin in this cycle still counts.
               state_d    = ST_VEND;
               dispense_d = 1'b1;
               credit_d   = (w_coin_ok ? w_sum[CREDIT_W-1:0] : credit_q) - c_price;
            end else if (w_coin_ok) begin
               credit_d = w_sum[CREDIT_W-1:0];
`ifdef VEND_CANCEL_EN
               cancel_pend_d = cancel;
            end else if (w_cancel_req && (credit_q != '0)) begin
               // First refund pulse issues on entry to REFUND.
               state_d  = (credit_q == c_one) ? ST_IDLE : ST_REFUND;
               change_d = 1'b1;
               credit_d = credit_q - c_one;
`endif
            end
         end
         ST_VEND: begin
            if (dispense_ack) begin
               dispense_d = 1'b0;
               if (credit_q != '0) begin
                  // First change pulse in the cycle right after the ack.
                  change_d = 1'b1;
                  credit_d = credit_q - c_one;
                  state_d  = (credit_q == c_one) ? ST_IDLE : ST_CHANGE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_CHANGE, ST_REFUND: begin
            if (credit_q != '0) begin
               change_d = 1'b1;
               credit_d = credit_q - c_one;
               if (credit_q == c_one) begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            credit_d   = '0;
            dispense_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         credit_q      <= '0;
         dispense_q    <= 1'b0;
         change_q      <= 1'b0;
         coin_reject_q <= 1'b0;
`ifdef VEND_CANCEL_EN
         cancel_pend_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         dispense_q    <= dispense_d;
         change_q      <= change_d;
         coin_reject_q <= coin_reject_d;
`ifdef VEND_CANCEL_EN
         cancel_pend_q <= cancel_pend_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vend_machine_param.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_vend_machine_param                                          |
// | Purpose  : Self-checking bench for vend_machine_param (default params:    |
// |            PRICE=3, MAX_CREDIT=15). Directed scenarios followed by random |
// |            purchases checked against a transaction-level credit model.    |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_vend_machine_param;

   localparam int CW    = 8;
   localparam int PRICE = 3;
   localparam int MAXC  = 15;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          coin_valid = 1'b0;
   logic [CW-1:0] coin_val = '0;
   logic          cancel = 1'b0;
   logic          dispense_ack = 1'b0;
   logic          coin_ready, coin_reject, dispense, change;
   logic [CW-1:0] credit;

   int n_assert = 0;
   int n_fail   = 0;

   vend_machine_param #(.CREDIT_W(CW), .PRICE(PRICE), .MAX_CREDIT(MAXC)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .cancel       (cancel),
      .dispense_ack (dispense_ack),
      .coin_ready   (coin_ready),
      .coin_reject  (coin_reject),
      .dispense     (dispense),
      .change       (change),
      .credit       (credit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change at negedge; outputs are sampled at the following negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic coin(input int v);
      coin_valid = 1'b1;
      coin_val   = CW'(v);
      step();
      coin_valid = 1'b0;
      coin_val   = '0;
   endtask

   // Counts change pulses until the machine is back to accepting coins.
   task automatic count_change(output int cnt);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (change) cnt++;
         if (coin_ready) break;
         step();
      end
   endtask

   initial begin
      int cnt, m, v, d, nc;
      bit acc;

      // Reset state, held asynchronously before any clock edge matters.
      #2;
      chk("rst_credit", credit, 0);
      chk("rst_dispense", dispense, 0);
      chk("rst_change", change, 0);
      chk("rst_reject", coin_reject, 0);
      chk("rst_ready", coin_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // Exact pay 1 + 2, ack held for 5 cycles, coin during VEND rejected.
      coin(1);
      chk("exact_c1", credit, 1);
      chk("exact_rej1", coin_reject, 0);
      coin(2);
      chk("exact_c3", credit, 3);
      chk("exact_nodisp", dispense, 0);
      step();
      chk("exact_disp", dispense, 1);
      chk("exact_vend_credit", credit, 0);
      chk("exact_vend_ready", coin_ready, 0);
      coin(1);
      chk("vend_coin_reject", coin_reject, 1);
      chk("vend_coin_credit", credit, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("held_disp", dispense, 1);
         chk("held_reject_pulse", coin_reject, 0);
      end
      dispense_ack = 1'b1;
      step();
      dispense_ack = 1'b0;
      chk("exact_ack_disp", dispense, 0);
      chk("exact_ack_ready", coin_ready, 1);
      count_change(cnt);
      for (int i = 0; i < 3; i++) begin
         step();
         if (change) cnt++;
      end
      chk("exact_change_cnt", cnt, 0);

      // Ack outside VEND is ignored.
      dispense_ack = 1'b1;
      step();
      dispense_ack = 1'b0;
      chk("idle_ack_ready", coin_ready, 1);
      chk("idle_ack_change", change, 0);
      chk("idle_ack_credit", credit, 0);

      // Overpay 2 + 2: one change pulse.
      coin(2);
      coin(2);
      chk("over_c4", credit, 4);
      step();
      chk("over_disp", dispense, 1);
      chk("over_vend_credit", credit, 1);
      dispense_ack = 1'b1;
      step();
      dispense_ack = 1'b0;
      count_change(cnt);
      step();
      if (change) cnt++;
      chk("over_change_cnt", cnt, 1);
      chk("over_credit0", credit, 0);
      chk("over_idle", coin_ready, 1);

      // Zero coin and out-of-range coin from IDLE are rejected.
      coin(0);
      chk("zero_reject", coin_reject, 1);
      chk("zero_credit", credit, 0);
      coin(16);
      chk("big_reject", coin_reject, 1);
      chk("big_credit", credit, 0);

      // Overflow: credit 14 + coin 3 -> reject; vend then takes PRICE from 14.
      coin(14);
      chk("ovf_c14", credit, 14);
      chk("ovf_acc", coin_reject, 0);
      coin(3);
      chk("ovf_reject", coin_reject, 1);
      chk("ovf_credit", credit, 14 - PRICE);
      chk("ovf_disp", dispense, 1);
      dispense_ack = 1'b1;
      step();
      dispense_ack = 1'b0;
      count_change(cnt);
      chk("ovf_change_cnt", cnt, 14 - PRICE);
      chk("ovf_credit0", credit, 0);

      // Cancel with credit 2.
      coin(2);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      cnt = (change) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (change) cnt++;
      end
`ifdef VEND_CANCEL_EN
      chk("cancel_pulses", cnt, 2);
      chk("cancel_credit", credit, 0);
      chk("cancel_idle", coin_ready, 1);
`else
      chk("nocancel_pulses", cnt, 0);
      chk("nocancel_credit", credit, 2);
      coin(1);
      step();
      chk("nocancel_disp", dispense, 1);
      dispense_ack = 1'b1;
      step();
      dispense_ack = 1'b0;
      chk("nocancel_idle", coin_ready, 1);
      chk("nocancel_credit0", credit, 0);
`endif

      // Reset mid-CHANGE: credit 3 left after vend, reset after first pulse.
      coin(6);
      step();
      chk("rstchg_vend_credit", credit, 3);
      dispense_ack = 1'b1;
      step();
      dispense_ack = 1'b0;
      chk("rstchg_first_pulse", change, 1);
      chk("rstchg_credit2", credit, 2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rstchg_credit", credit, 0);
      chk("rstchg_change", change, 0);
      chk("rstchg_disp", dispense, 0);
      chk("rstchg_ready", coin_ready, 1);
      chk("rstchg_reject", coin_reject, 0);
      cnt = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (change) cnt++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (change) cnt++;
      end
      chk("rstchg_no_pulses", cnt, 0);
      chk("rstchg_after_credit", credit, 0);

      // Random purchases against a transaction-level credit model.
      for (int t = 0; t < 40; t++) begin
         m  = 0;
         nc = 0;
         while (m < PRICE && nc < 30) begin
            v   = int'($urandom_range(0, 17));
            acc = (v != 0) && (m + v <= MAXC);
            coin(v);
            nc++;
            if (acc) m = m + v;
            chk("rnd_reject", coin_reject, acc ? 0 : 1);
            chk("rnd_credit", credit, m);
         end
         if (m < PRICE) begin
            chk("rnd_vend_reached", m, PRICE);
         end else begin
            step();
            chk("rnd_disp", dispense, 1);
            chk("rnd_vend_credit", credit, m - PRICE);
            d = int'($urandom_range(0, 4));
            for (int i = 0; i < d; i++) begin
               step();
               chk("rnd_disp_held", dispense, 1);
            end
            dispense_ack = 1'b1;
            step();
            dispense_ack = 1'b0;
            chk("rnd_ack_disp", dispense, 0);
            count_change(cnt);
            chk("rnd_change_cnt", cnt, m - PRICE);
            chk("rnd_final_credit", credit, 0);
            chk("rnd_final_ready", coin_ready, 1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
